// File: rtl/uart_cnt_reporter.sv
// -----------------------------------------------------------------------------
// uart_cnt_reporter
//
// Converts a 14-bit binary counter value into four ASCII decimal digits
// (thousands first, leading zeros kept) and sends them one byte at a time
// through a byte-oriented UART transmitter. When NEWLINE is 1, CR and LF
// follow the digits. Values above 9999 are reported as 9999.
//
// Flow: IDLE -> CONVERT (14 cycles of double-dabble) -> SEND/WAIT_DONE once
// per byte -> IDLE with a one-cycle o_report_done pulse.
//
// Parameters
//   NEWLINE        1: append 0x0D 0x0A after the digits (6 bytes per report)
//                  0: digits only (4 bytes per report)
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   i_digit[13:0]  unsigned counter value, latched when a request is accepted
//   i_report       report request, only looked at while idle
//   i_tx_done      one-cycle pulse from the UART: current byte finished
//   o_tx_start     one-cycle pulse to the UART: launch o_tx_data
//   o_tx_data[7:0] byte for the UART, held until its i_tx_done
//   o_busy         high from request acceptance until the last byte's done
//   o_report_done  one-cycle pulse when the last byte has completed
// -----------------------------------------------------------------------------
module uart_cnt_reporter #(
    parameter int NEWLINE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] i_digit,
    input  logic        i_report,
    input  logic        i_tx_done,
    output logic        o_tx_start,
    output logic [7:0]  o_tx_data,
    output logic        o_busy,
    output logic        o_report_done
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] CONVERT   = 2'd1;
    localparam logic [1:0] SEND      = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    // Index of the final byte of a report.
    localparam logic [2:0] LAST_IDX = (NEWLINE != 0) ? 3'd5 : 3'd3;

    // The conversion runs exactly one iteration per input bit.
    localparam logic [3:0] LAST_SHIFT = 4'd13;

    localparam logic [13:0] MAX_VALUE = 14'd9999;

    logic [1:0]  state;
    logic [13:0] value;       // latched binary value, shifted out MSB first
    logic [15:0] bcd;         // four BCD nibbles, thousands in [15:12]
    logic [3:0]  shift_cnt;
    logic [2:0]  byte_idx;
    logic [15:0] bcd_adj;

    // Clamp values that do not fit in four decimal digits.
    function automatic logic [13:0] sat_value(input logic [13:0] v);
        return (v > MAX_VALUE) ? MAX_VALUE : v;
    endfunction

    // Double-dabble correction: any nibble >= 5 gets +3 so that the
    // following left shift carries correctly into the next decimal digit.
    function automatic logic [15:0] add3(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int n = 0; n < 4; n++) begin
            if (b[n*4 +: 4] >= 4'd5) begin
                r[n*4 +: 4] = b[n*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Byte selection in transmit order.
    function automatic logic [7:0] byte_at(input logic [2:0] idx,
                                           input logic [15:0] b);
        logic [7:0] r;
        case (idx)
            3'd0:    r = {4'h3, b[15:12]};
            3'd1:    r = {4'h3, b[11:8]};
            3'd2:    r = {4'h3, b[7:4]};
            3'd3:    r = {4'h3, b[3:0]};
            3'd4:    r = 8'h0D;
            3'd5:    r = 8'h0A;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    always_comb begin
        bcd_adj = add3(bcd);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            value         <= '0;
            bcd           <= '0;
            shift_cnt     <= '0;
            byte_idx      <= '0;
            o_tx_start    <= 1'b0;
            o_tx_data     <= 8'h00;
            o_busy        <= 1'b0;
            o_report_done <= 1'b0;
        end else begin
            // Both strobes are single-cycle unless re-armed below.
            o_tx_start    <= 1'b0;
            o_report_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (i_report) begin
                        value     <= sat_value(i_digit);
                        bcd       <= '0;
                        shift_cnt <= '0;
                        byte_idx  <= '0;
                        o_busy    <= 1'b1;
                        state     <= CONVERT;
                    end
                end

                CONVERT: begin
                    // Correct, then shift the binary MSB into the BCD LSB.
                    bcd       <= {bcd_adj[14:0], value[13]};
                    value     <= {value[12:0], 1'b0};
                    shift_cnt <= shift_cnt + 4'd1;
                    if (shift_cnt == LAST_SHIFT) begin
                        state <= SEND;
                    end
                end

                SEND: begin
                    o_tx_data  <= byte_at(byte_idx, bcd);
                    o_tx_start <= 1'b1;
                    state      <= WAIT_DONE;
                end

                WAIT_DONE: begin
                    // o_tx_data is left untouched here, so it stays stable
                    // for the whole byte time.
                    if (i_tx_done) begin
                        if (byte_idx == LAST_IDX) begin
                            byte_idx      <= '0;
                            o_busy        <= 1'b0;
                            o_report_done <= 1'b1;
                            state         <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                            state    <= SEND;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cnt_reporter.sv
// -----------------------------------------------------------------------------
// tb_uart_cnt_reporter
//
// Directed bench for uart_cnt_reporter. Two instances share clock and reset:
// dut_a with NEWLINE=1 and dut_b with NEWLINE=0. A small UART model per
// instance logs every launched byte, holds a 20-cycle byte time, returns a
// one-cycle done pulse and watches that o_tx_data stays put meanwhile.
// -----------------------------------------------------------------------------
module tb_uart_cnt_reporter;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] digit_a, digit_b;
    logic [1:0]  report, mdl_done, spur, tx_done, tx_start, busy, rdone;
    logic [7:0]  data_a, data_b;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign tx_done = mdl_done | spur;

    uart_cnt_reporter #(.NEWLINE(1)) dut_a (
        .clk           (clk),
        .reset         (reset),
        .i_digit       (digit_a),
        .i_report      (report[0]),
        .i_tx_done     (tx_done[0]),
        .o_tx_start    (tx_start[0]),
        .o_tx_data     (data_a),
        .o_busy        (busy[0]),
        .o_report_done (rdone[0])
    );

    uart_cnt_reporter #(.NEWLINE(0)) dut_b (
        .clk           (clk),
        .reset         (reset),
        .i_digit       (digit_b),
        .i_report      (report[1]),
        .i_tx_done     (tx_done[1]),
        .o_tx_start    (tx_start[1]),
        .o_tx_data     (data_b),
        .o_busy        (busy[1]),
        .o_report_done (rdone[1])
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- UART model ----------------
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         cnt[2];
    logic [7:0] held[2];
    bit         hold_chk[2];
    int         done_cnt[2];
    logic [7:0] cur;

    initial begin
        mdl_done = '0;
        for (int k = 0; k < 2; k++) begin
            cnt[k] = 0; held[k] = 8'h00; hold_chk[k] = 0; done_cnt[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                cur = (k == 0) ? data_a : data_b;
                mdl_done[k] = 1'b0;
                if (reset) hold_chk[k] = 0;
                if (hold_chk[k]) check((k == 0) ? "hold_a" : "hold_b", cur, held[k]);
                if (cnt[k] > 0) begin
                    cnt[k]--;
                    if (cnt[k] == 0) begin
                        mdl_done[k] = 1'b1;
                        hold_chk[k] = 0;
                    end
                end
                if (tx_start[k]) begin
                    if (k == 0) q0.push_back(cur); else q1.push_back(cur);
                    held[k] = cur;
                    hold_chk[k] = 1;
                    cnt[k] = 20;
                end
                if (rdone[k]) done_cnt[k]++;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic clear_log();
        q0.delete();
        q1.delete();
        done_cnt[0] = 0;
        done_cnt[1] = 0;
    endtask

    // Called just after a falling edge; returns one falling edge after the
    // accepting rising edge.
    task automatic request(input int k, input logic [13:0] d);
        if (k == 0) digit_a = d; else digit_b = d;
        report[k] = 1'b1;
        @(negedge clk);
        report[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input string tag);
        bit ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rdone[k]) begin ok = 1; break; end
        end
        check({tag, "_done_seen"}, 32'(ok), 1);
        if (ok) check({tag, "_busy_low_at_done"}, 32'(busy[k]), 0);
    endtask

    task automatic wait_q0(input int n, input string tag);
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (q0.size() >= n) begin ok = 1; break; end
        end
        check({tag, "_bytes_reached"}, 32'(ok), 1);
    endtask

    task automatic check_seq(input int k, input string tag,
                             input logic [47:0] exp, input int n);
        int sz;
        logic [7:0] got;
        sz = (k == 0) ? q0.size() : q1.size();
        check({tag, "_count"}, sz, n);
        for (int i = 0; i < n; i++) begin
            if (i < sz) got = (k == 0) ? q0[i] : q1[i];
            else        got = 'x;
            check($sformatf("%s_byte%0d", tag, i), 32'(got), 32'(exp[47-8*i -: 8]));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset   = 1'b1;
        report  = '0;
        spur    = '0;
        digit_a = '0;
        digit_b = '0;
        repeat (3) @(negedge clk);
        check("rst_tx_start", 32'(tx_start[0]), 0);
        check("rst_tx_data",  32'(data_a), 0);
        check("rst_busy",     32'(busy[0]), 0);
        check("rst_done",     32'(rdone[0]), 0);
        check("rst_b_busy",   32'(busy[1]), 0);
        reset = 1'b0;

        // 1234 requested on the first edge after reset release; latency check.
        clear_log();
        request(0, 14'd1234);
        check("t1_busy_after_N", 32'(busy[0]), 1);
        repeat (14) @(negedge clk);
        check("t1_no_start_N14", 32'(tx_start[0]), 0);
        @(negedge clk);
        check("t1_start_N15", 32'(tx_start[0]), 1);
        check("t1_first_data", 32'(data_a), 32'h31);
        wait_done(0, "t1");
        repeat (3) @(negedge clk);
        check_seq(0, "t1", 48'h31323334_0D0A, 6);
        check("t1_done_pulses", done_cnt[0], 1);

        // 16383 saturates; next request issued while o_report_done is high.
        clear_log();
        request(0, 14'd16383);
        wait_done(0, "t2");
        request(0, 14'd0);
        check("t3_accept_on_done", 32'(busy[0]), 1);
        check_seq(0, "t2", 48'h39393939_0D0A, 6);
        check("t2_done_pulses", done_cnt[0], 1);
        clear_log();
        wait_done(0, "t3");
        repeat (3) @(negedge clk);
        check_seq(0, "t3", 48'h30303030_0D0A, 6);

        // NEWLINE=0 instance.
        clear_log();
        request(1, 14'd9876);
        wait_done(1, "t4");
        repeat (3) @(negedge clk);
        check_seq(1, "t4", 48'h39383736_0000, 4);
        check("t4_done_pulses", done_cnt[1], 1);
        check("t4_a_idle", q0.size(), 0);

        // Spurious done during CONVERT, extra request during byte 2,
        // i_digit changed after latching.
        clear_log();
        request(0, 14'd5678);
        repeat (3) @(negedge clk);
        spur[0] = 1'b1;
        @(negedge clk);
        spur[0] = 1'b0;
        wait_q0(2, "t5");
        digit_a   = 14'd1111;
        report[0] = 1'b1;
        @(negedge clk);
        report[0] = 1'b0;
        digit_a   = 14'd3333;
        wait_done(0, "t5");
        repeat (20) @(negedge clk);
        check_seq(0, "t5", 48'h35363738_0D0A, 6);
        check("t5_done_pulses", done_cnt[0], 1);
        check("t5_no_queued_report", 32'(busy[0]), 0);

        // Reset while waiting for byte 3 done.
        clear_log();
        request(0, 14'd5555);
        wait_q0(3, "t6");
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_tx_start", 32'(tx_start[0]), 0);
        check("t6_rst_tx_data",  32'(data_a), 0);
        check("t6_rst_busy",     32'(busy[0]), 0);
        check("t6_rst_done",     32'(rdone[0]), 0);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (40) @(negedge clk);
        check("t6_no_more_start", q0.size(), 3);
        check("t6_no_done", done_cnt[0], 0);
        clear_log();
        request(0, 14'd42);
        wait_done(0, "t7");
        repeat (3) @(negedge clk);
        check_seq(0, "t7", 48'h30303432_0D0A, 6);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cnt_reporter.md
UART_CNT_REPORTER -- requirements
Module: uart_cnt_reporter

Interface
REQ-001 Parameter: NEWLINE, default 1, meaning: when 1, append CR (0x0D) and LF (0x0A) after the four digit bytes.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 i_digit  input  14  counter value to report, unsigned binary (upcounter qout).
REQ-005 i_report  input  1  report request; sampled only in IDLE.
REQ-006 i_tx_done  input  1  one-cycle pulse from uart: current tx byte finished.
REQ-007 o_tx_start  output  1  one-cycle pulse to uart start: launch o_tx_data.
REQ-008 o_tx_data  output  8  byte for uart tx_data.
REQ-009 o_busy  output  1  high from request acceptance until the last byte's i_tx_done.
REQ-010 o_report_done  output  1  one-cycle pulse after the last byte completes.

Function
REQ-011 FSM states: IDLE, CONVERT, SEND, WAIT_DONE.
REQ-012 IDLE: at edge N with i_report=1, latch i_digit, clear BCD register and shift counter, go to CONVERT, set o_busy=1.
REQ-013 Latch saturation: i_digit > 9999 is latched as 9999.
REQ-014 CONVERT: sequential double-dabble (add-3 where BCD nibble >= 5, then shift left by 1 bit), one bit per clock, exactly 14 iterations on edges N+1..N+14; go to SEND at edge N+14.
REQ-015 Byte order: thousands, hundreds, tens, ones as ASCII 0x30+digit; leading zeros are sent; then 0x0D, 0x0A when NEWLINE=1.
REQ-016 Total bytes per report: 6 when NEWLINE=1, 4 when NEWLINE=0.
REQ-017 SEND: at the next edge, drive o_tx_data with the current byte, pulse o_tx_start high for one cycle, and go to WAIT_DONE; the first o_tx_start is high after edge N+15.
REQ-018 o_tx_data stays stable from its o_tx_start until the matching i_tx_done is sampled.
REQ-019 WAIT_DONE: i_tx_done sampled high advances the byte index and goes to SEND if bytes remain, else to IDLE.
REQ-020 Final done: in the same edge, o_busy goes low and o_report_done pulses for one cycle.
REQ-021 i_tx_done is ignored in IDLE, CONVERT and SEND; only one o_tx_start may be outstanding.
REQ-022 i_report is ignored while o_busy=1; no queuing.
REQ-023 i_report may be asserted in the same cycle that o_report_done pulses; the block is in IDLE then, so the request is accepted.
REQ-024 i_digit changes after latching do not affect the report in progress.
REQ-025 Throughput: at most one byte per i_tx_done; minimum one cycle of SEND between i_tx_done and the next o_tx_start.

Reset
REQ-026 Reset values: state=IDLE, o_tx_start=0, o_tx_data=8'h00, o_busy=0, o_report_done=0; latched value, BCD register, byte index and shift counter cleared.
REQ-027 Reset asserted mid-report aborts immediately with no further o_tx_start; a byte already launched in the uart is not recalled.
REQ-028 After reset release, the block accepts a new i_report on the first edge.

Verification
REQ-029 i_digit=1234, NEWLINE=1, uart model returns done 20 cycles after each start -> bytes 0x31,0x32,0x33,0x34,0x0D,0x0A; one o_report_done pulse.
REQ-030 i_digit=0 -> 0x30,0x30,0x30,0x30,0x0D,0x0A; i_digit=16383 -> 0x39 x4,0x0D,0x0A (saturation).
REQ-031 i_report at edge N -> first o_tx_start high after edge N+15, o_busy high after edge N; NEWLINE=0 with 9876 -> exactly 4 bytes 0x39,0x38,0x37,0x36.
REQ-032 Second i_report during byte 2, plus spurious i_tx_done during CONVERT -> ignored; byte sequence and count unchanged.
REQ-033 Reset pulsed while waiting for byte 3 done -> all outputs at reset values, no further o_tx_start; a subsequent i_report=42 -> 0x30,0x30,0x34,0x32,0x0D,0x0A.
